// File: rtl/and4_vector_sequencer.sv
// Buffers {a,b,exp} vectors, then applies each to a combinational datapath and checks its result.
// Per vector: APPLY, SETTLE hold cycles, CHECK; status counters saturate and hold until the next start.
module and4_vector_sequencer #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 16,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [WIDTH-1:0] vec_a,
  input  logic [WIDTH-1:0] vec_b,
  input  logic [WIDTH-1:0] vec_exp,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  input  logic [WIDTH-1:0] dut_c,
  output logic             err_pulse,
  output logic [15:0]      err_count,
  output logic [15:0]      vec_count,
  output logic [15:0]      first_err_idx,
  output logic             first_err_valid
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_APPLY  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] dut_a_q, dut_a_d, dut_b_q, dut_b_d, exp_q, exp_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic             err_pulse_q, err_pulse_d;
  logic [15:0]      err_count_q, err_count_d, vec_count_q, vec_count_d;
  logic [15:0]      first_err_idx_q, first_err_idx_d;
  logic             first_err_valid_q, first_err_valid_d;

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [WIDTH-1:0] mem_e [DEPTH];

  logic empty, full, wr_en, mismatch;

  // Extra MSB on the pointers tells a full FIFO from an empty one.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign vec_ready = (state_q == S_IDLE) && !full;
  assign wr_en     = vec_valid && vec_ready;
  assign mismatch  = (dut_c !== exp_q);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_a[wr_ptr_q[AW-1:0]] <= vec_a;
      mem_b[wr_ptr_q[AW-1:0]] <= vec_b;
      mem_e[wr_ptr_q[AW-1:0]] <= vec_exp;
    end
  end

  always_comb begin
    state_d           = state_q;
    wr_ptr_d          = wr_ptr_q + {{AW{1'b0}}, wr_en};
    rd_ptr_d          = rd_ptr_q;
    dut_a_d           = dut_a_q;
    dut_b_d           = dut_b_q;
    exp_d             = exp_q;
    cnt_d             = cnt_q;
    err_pulse_d       = 1'b0;
    err_count_d       = err_count_q;
    vec_count_d       = vec_count_q;
    first_err_idx_d   = first_err_idx_q;
    first_err_valid_d = first_err_valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_count_d       = '0;
          vec_count_d       = '0;
          first_err_idx_d   = '0;
          first_err_valid_d = 1'b0;
          // A vector written this same cycle counts toward the run.
          state_d = (wr_en || !empty) ? S_APPLY : S_DONE;
        end
      end
      S_APPLY: begin
        dut_a_d  = mem_a[rd_ptr_q[AW-1:0]];
        dut_b_d  = mem_b[rd_ptr_q[AW-1:0]];
        exp_d    = mem_e[rd_ptr_q[AW-1:0]];
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        cnt_d    = SETTLE_INIT;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_CHECK;
        else             cnt_d   = cnt_q - {{(SW-1){1'b0}}, 1'b1};
      end
      S_CHECK: begin
        vec_count_d = (vec_count_q == 16'hFFFF) ? vec_count_q : vec_count_q + 16'd1;
        if (mismatch) begin
          err_pulse_d = 1'b1;
          err_count_d = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
          if (!first_err_valid_q) begin
            first_err_idx_d   = vec_count_q;
            first_err_valid_d = 1'b1;
          end
        end
        state_d = empty ? S_DONE : S_APPLY;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= S_IDLE;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      dut_a_q           <= '0;
      dut_b_q           <= '0;
      exp_q             <= '0;
      cnt_q             <= '0;
      err_pulse_q       <= 1'b0;
      err_count_q       <= '0;
      vec_count_q       <= '0;
      first_err_idx_q   <= '0;
      first_err_valid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      dut_a_q           <= dut_a_d;
      dut_b_q           <= dut_b_d;
      exp_q             <= exp_d;
      cnt_q             <= cnt_d;
      err_pulse_q       <= err_pulse_d;
      err_count_q       <= err_count_d;
      vec_count_q       <= vec_count_d;
      first_err_idx_q   <= first_err_idx_d;
      first_err_valid_q <= first_err_valid_d;
    end
  end

  assign busy            = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign done            = (state_q == S_DONE);
  assign dut_a           = dut_a_q;
  assign dut_b           = dut_b_q;
  assign err_pulse       = err_pulse_q;
  assign err_count       = err_count_q;
  assign vec_count       = vec_count_q;
  assign first_err_idx   = first_err_idx_q;
  assign first_err_valid = first_err_valid_q;
endmodule

// File: tb/tb_and4_vector_sequencer.sv
// Bench for and4_vector_sequencer: an AND datapath stand-in, a run-level timing model checked every
// cycle, and directed scenarios with hand-computed literal expectations.
module tb_and4_vector_sequencer;
  localparam int W = 4, D = 16, S = 1, P = S + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic vec_valid = 1'b0, start = 1'b0, x_en = 1'b0, chk_en = 1'b0;
  logic [W-1:0] vec_a = '0, vec_b = '0, vec_exp = '0;
  logic vec_ready, busy, done, err_pulse, first_err_valid;
  logic [W-1:0] dut_a, dut_b, dut_c;
  logic [15:0] err_count, vec_count, first_err_idx;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  // AND datapath; the (6,6) operand pair can be made to return X.
  assign dut_c = (x_en && dut_a == 4'h6 && dut_b == 4'h6) ? 4'bxxxx : (dut_a & dut_b);

  and4_vector_sequencer #(.WIDTH(W), .DEPTH(D), .SETTLE(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_a(vec_a), .vec_b(vec_b), .vec_exp(vec_exp), .start(start), .busy(busy), .done(done),
    .dut_a(dut_a), .dut_b(dut_b), .dut_c(dut_c), .err_pulse(err_pulse), .err_count(err_count),
    .vec_count(vec_count), .first_err_idx(first_err_idx), .first_err_valid(first_err_valid));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: a run of N vectors starting at cycle k=0 is busy for k=1..N*P, done at N*P+1.
  typedef struct packed { logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] e; logic x; } vec_t;
  vec_t m_fifo[$];
  vec_t m_runv[$];
  bit   m_fail[$];
  int   m_k = 0;
  bit   m_run = 0, m_have = 0;
  logic [W-1:0] m_da = '0, m_db = '0;

  function automatic bit vec_fails(input vec_t v);
    return (v.x && v.a == 4'h6 && v.b == 4'h6) || ((v.a & v.b) != v.e);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fifo.delete(); m_runv.delete(); m_fail.delete();
      m_run = 0; m_have = 0; m_k = 0; m_da = '0; m_db = '0;
    end else if (m_run) begin
      m_k++;
      if (m_k == m_runv.size() * P + 2) m_run = 0;
      else if (m_k >= 2 && (m_k - 2) % P == 0 && (m_k - 2) / P < m_runv.size()) begin
        m_da = m_runv[(m_k - 2) / P].a;
        m_db = m_runv[(m_k - 2) / P].b;
      end
    end else begin
      if (vec_valid && m_fifo.size() < D) m_fifo.push_back({vec_a, vec_b, vec_exp, x_en});
      if (start) begin
        m_runv = m_fifo;
        m_fifo.delete();
        m_fail.delete();
        foreach (m_runv[i]) m_fail.push_back(vec_fails(m_runv[i]));
        m_run = 1; m_have = 1; m_k = 1;
      end
    end
  end

  always @(negedge clk) begin : cmp
    int n, c, ec, fi;
    bit fv, ep;
    if (chk_en) begin
      n = m_runv.size();
      if (m_run) c = ((m_k - 1) / P > n) ? n : (m_k - 1) / P;
      else       c = m_have ? n : 0;
      ec = 0; fv = 0; fi = 0;
      for (int j = 0; j < c; j++)
        if (m_fail[j]) begin
          ec++;
          if (!fv) begin fv = 1; fi = j; end
        end
      ep = 0;
      if (m_run && m_k >= P + 1 && (m_k - 1) % P == 0) ep = m_fail[(m_k - 1) / P - 1];
      check("busy", {31'd0, busy}, {31'd0, m_run && m_k <= n * P});
      check("done", {31'd0, done}, {31'd0, m_run && m_k == n * P + 1});
      check("vec_ready", {31'd0, vec_ready}, {31'd0, !m_run && m_fifo.size() < D});
      check("err_pulse", {31'd0, err_pulse}, {31'd0, ep});
      check("vec_count", {16'd0, vec_count}, c);
      check("err_count", {16'd0, err_count}, ec);
      check("first_err_valid", {31'd0, first_err_valid}, {31'd0, fv});
      check("first_err_idx", {16'd0, first_err_idx}, fi);
      check("dut_a", {28'd0, dut_a}, {28'd0, m_da});
      check("dut_b", {28'd0, dut_b}, {28'd0, m_db});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [3:0] b, input logic [3:0] e, input logic st);
    vec_valid = 1'b1; vec_a = a; vec_b = b; vec_exp = e; start = st;
    tick();
    vec_valid = 1'b0; start = 1'b0;
  endtask

  // start is sampled at the first tick; lat counts cycles until done is seen.
  task automatic run(input int hold_valid, output int lat, output int pulses);
    start = 1'b1;
    lat = 0; pulses = 0;
    do begin
      vec_valid = (lat < hold_valid);
      tick();
      start = 1'b0;
      lat++;
      if (err_pulse) pulses++;
      if (lat <= hold_valid && lat > 0) check("ready_busy", {31'd0, vec_ready}, 32'd0);
    end while (!done && lat < 2000);
    vec_valid = 1'b0;
    if (lat >= 2000) check("done_timeout", 32'd0, 32'd1);
  endtask

  int lat, pulses;

  initial begin
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    #20;
    check("rst_ready", {31'd0, vec_ready}, 32'd1);
    check("rst_vec_count", {16'd0, vec_count}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: three passing vectors
    load(4'h3, 4'h5, 4'h1, 1'b0);
    load(4'hF, 4'hF, 4'hF, 1'b0);
    load(4'hA, 4'h5, 4'h0, 1'b0);
    run(0, lat, pulses);
    check("t1_latency", lat, 32'd10);
    check("t1_vec_count", {16'd0, vec_count}, 32'd3);
    check("t1_err_count", {16'd0, err_count}, 32'd0);
    check("t1_first_valid", {31'd0, first_err_valid}, 32'd0);
    tick();

    // 2: two mismatches; last vector written in the start cycle
    load(4'hC, 4'hA, 4'h8, 1'b0);
    load(4'h3, 4'h3, 4'h0, 1'b0);
    load(4'hF, 4'h1, 4'h1, 1'b0);
    vec_valid = 1'b1; vec_a = 4'h7; vec_b = 4'h7; vec_exp = 4'h0;
    run(1, lat, pulses);
    check("t2_latency", lat, 32'd13);
    check("t2_err_count", {16'd0, err_count}, 32'd2);
    check("t2_first_idx", {16'd0, first_err_idx}, 32'd1);
    check("t2_first_valid", {31'd0, first_err_valid}, 32'd1);
    check("t2_pulses", pulses, 32'd2);
    tick();

    // 3: empty run
    run(0, lat, pulses);
    check("t3_latency", lat, 32'd1);
    check("t3_vec_count", {16'd0, vec_count}, 32'd0);
    tick();

    // 4: overfill, then push while busy
    for (int i = 0; i < D + 2; i++) begin
      vec_valid = 1'b1; vec_a = 4'(i); vec_b = ~4'(i); vec_exp = 4'h0;
      tick();
    end
    vec_valid = 1'b0;
    check("t4_full_ready", {31'd0, vec_ready}, 32'd0);
    run(5, lat, pulses);
    check("t4_latency", lat, 32'd49);
    check("t4_vec_count", {16'd0, vec_count}, 32'd16);
    tick();
    check("t4_ready_after", {31'd0, vec_ready}, 32'd1);

    // 5: X on dut_c counts as mismatch
    x_en = 1'b1;
    load(4'h6, 4'h6, 4'h6, 1'b0);
    load(4'h5, 4'h3, 4'h1, 1'b0);
    run(0, lat, pulses);
    x_en = 1'b0;
    check("t5_err_count", {16'd0, err_count}, 32'd1);
    check("t5_first_idx", {16'd0, first_err_idx}, 32'd0);
    check("t5_vec_count", {16'd0, vec_count}, 32'd2);
    tick();

    // 6: reset during SETTLE of the second vector
    load(4'h1, 4'h1, 4'h1, 1'b0);
    load(4'h2, 4'h2, 4'h2, 1'b0);
    load(4'h3, 4'h3, 4'h3, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #1 rst_n = 1'b0;
    #1;
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_ready", {31'd0, vec_ready}, 32'd1);
    check("t6_dut_a", {28'd0, dut_a}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run(0, lat, pulses);
    check("t6_latency", lat, 32'd1);
    check("t6_vec_count", {16'd0, vec_count}, 32'd0);
    tick();
    tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
